// File: rtl/motor_meas_pkg.sv
// Shared types and constants for the motor drive-line measurement slice.
// Exports the per-motor status encoding and the default PWM period exponent.
package motor_meas_pkg;

    localparam int PERIOD_LOG2_DEF = 10;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        DRIVE = 2'b01,
        BRAKE = 2'b10,
        FAULT = 2'b11
    } stat_e;

endpackage

// File: rtl/motor_cmd_decode_if.sv
// Bundle between the drive lines under test and the command decoder.
// master: drives en and the four drive lines; slave: returns meas/stat/vld.
interface motor_cmd_decode_if
    import motor_meas_pkg::*;
#(
    parameter int PERIOD_LOG2 = PERIOD_LOG2_DEF
) ();

    logic                 en;
    logic                 fwd_lft;
    logic                 rev_lft;
    logic                 fwd_rht;
    logic                 rev_rht;
    logic [PERIOD_LOG2:0] lft_meas;
    logic [PERIOD_LOG2:0] rht_meas;
    stat_e                lft_stat;
    stat_e                rht_stat;
    logic                 meas_vld;

    modport master (
        output en, fwd_lft, rev_lft, fwd_rht, rev_rht,
        input  lft_meas, rht_meas, lft_stat, rht_stat, meas_vld
    );

    modport slave (
        input  en, fwd_lft, rev_lft, fwd_rht, rev_rht,
        output lft_meas, rht_meas, lft_stat, rht_stat, meas_vld
    );

endinterface

// File: rtl/motor_cmd_decode_pwm_duty_meas.sv
// One motor channel: samples fwd/rev, counts high cycles per window, classifies.
// Ports: clk, rst_n, en_i, win_last_i, fwd_i, rev_i -> meas_o (signed), stat_o.
module pwm_duty_meas
    import motor_meas_pkg::*;
#(
    parameter int PERIOD_LOG2 = PERIOD_LOG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 win_last_i,
    input  logic                 fwd_i,
    input  logic                 rev_i,
    output logic [PERIOD_LOG2:0] meas_o,
    output stat_e                stat_o
);

    localparam int CW = PERIOD_LOG2 + 1;
    localparam logic [CW-1:0] W    = CW'(1) << PERIOD_LOG2;
    localparam logic [CW-1:0] W_M1 = W - CW'(1);

    logic          fwd_smp_q;
    logic          rev_smp_q;
    logic [CW-1:0] fcnt_q;
    logic [CW-1:0] rcnt_q;
    logic [CW-1:0] f_fin;
    logic [CW-1:0] r_fin;
    logic [CW-1:0] meas_d;
    logic [CW-1:0] meas_q;
    stat_e         stat_d;
    stat_e         stat_q;

    // Final counts include the sample still sitting in the sample register.
    assign f_fin = fcnt_q + CW'(fwd_smp_q);
    assign r_fin = rcnt_q + CW'(rev_smp_q);

    always_comb begin
        stat_d = FAULT;
        meas_d = '0;
        unique case (1'b1)
            (f_fin == W) && (r_fin == W): stat_d = BRAKE;
            (f_fin == '0) && (r_fin == '0): stat_d = COAST;
            (f_fin != '0) && (r_fin == '0): begin
                stat_d = DRIVE;
                meas_d = (f_fin == W) ? W_M1 : f_fin;
            end
            (r_fin != '0) && (f_fin == '0): begin
                stat_d = DRIVE;
                meas_d = '0 - r_fin;
            end
            default: begin
                stat_d = FAULT;
                meas_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_smp_q <= 1'b0;
            rev_smp_q <= 1'b0;
            fcnt_q    <= '0;
            rcnt_q    <= '0;
            meas_q    <= '0;
            stat_q    <= COAST;
        end else if (!en_i) begin
            fwd_smp_q <= 1'b0;
            rev_smp_q <= 1'b0;
            fcnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            fwd_smp_q <= fwd_i;
            rev_smp_q <= rev_i;
            if (win_last_i) begin
                fcnt_q <= '0;
                rcnt_q <= '0;
                meas_q <= meas_d;
                stat_q <= stat_d;
            end else begin
                fcnt_q <= f_fin;
                rcnt_q <= r_fin;
            end
        end
    end

    assign meas_o = meas_q;
    assign stat_o = stat_q;

endmodule

// File: rtl/motor_cmd_decode.sv
// Reconstructs both motors' signed commands from their H-bridge drive lines.
// Ports: clk, rst_n, bus (slave): en + 4 drive lines in; meas/stat/meas_vld out.
module motor_cmd_decode
    import motor_meas_pkg::*;
#(
    parameter int PERIOD_LOG2 = PERIOD_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_cmd_decode_if.slave bus
);

    logic [PERIOD_LOG2-1:0] win_cnt_q;
    logic                   smp_vld_q;
    logic                   meas_vld_q;
    logic                   win_last;

    // win_cnt counts samples already held; it only advances once the
    // sample register carries a real sample, so window 0 ends after W samples.
    assign win_last = bus.en && smp_vld_q && (win_cnt_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            smp_vld_q  <= 1'b0;
            meas_vld_q <= 1'b0;
        end else if (!bus.en) begin
            win_cnt_q  <= '0;
            smp_vld_q  <= 1'b0;
            meas_vld_q <= 1'b0;
        end else begin
            smp_vld_q  <= 1'b1;
            meas_vld_q <= win_last;
            if (smp_vld_q) begin
                win_cnt_q <= win_cnt_q + 1'b1;
            end
        end
    end

    assign bus.meas_vld = meas_vld_q;

    pwm_duty_meas #(
        .PERIOD_LOG2 (PERIOD_LOG2)
    ) u_lft (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (bus.en),
        .win_last_i (win_last),
        .fwd_i      (bus.fwd_lft),
        .rev_i      (bus.rev_lft),
        .meas_o     (bus.lft_meas),
        .stat_o     (bus.lft_stat)
    );

    pwm_duty_meas #(
        .PERIOD_LOG2 (PERIOD_LOG2)
    ) u_rht (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (bus.en),
        .win_last_i (win_last),
        .fwd_i      (bus.fwd_rht),
        .rev_i      (bus.rev_rht),
        .meas_o     (bus.rht_meas),
        .stat_o     (bus.rht_stat)
    );

endmodule
